// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Writeback-stage arbiter. Buffers results from the ALU (src 0),
//                LSU (src 1) and MUL/DIV (src 2) in per-source FIFOs and
//                issues at most one register-file write per cycle using
//                round-robin priority. Raises wb_stall before any FIFO can
//                overflow and maintains the 64-bit retired-instruction count.
//  Ports       : clk           - clock, all state updates on the rising edge
//                rst           - asynchronous, active-low reset
//                alu_wb_inf    - src 0 result, packed exe_wb_inf_t:
//                                [38] instruction_valid, [37] register_write,
//                                [36:32] rd, [31:0] exe_result
//                mem_wb_inf    - src 1 result, same layout
//                mul_wb_inf    - src 2 result, same layout
//                wb_stall      - backpressure toward the core stall logic
//                rf_wr_en      - register-file write enable
//                rf_wr_addr    - register-file write address
//                rf_wr_data    - register-file write data
//                instret       - retired-instruction counter (wraps)
//                overflow_err  - sticky: a push was dropped at a full FIFO
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [38:0] alu_wb_inf,
    input  logic [38:0] mem_wb_inf,
    input  logic [38:0] mul_wb_inf,
    output logic        wb_stall,
    output logic        rf_wr_en,
    output logic [4:0]  rf_wr_addr,
    output logic [31:0] rf_wr_data,
    output logic [63:0] instret,
    output logic        overflow_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 37;  // {rd, exe_result}

    localparam logic [CW-1:0] c_cnt_full  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] c_cnt_stall = CW'(FIFO_DEPTH - 2);
    localparam logic [CW-1:0] c_cnt_one   = CW'(1);
    localparam logic [PW-1:0] c_ptr_one   = PW'(1);

    logic [38:0]   w_src      [3];
    logic [CW-1:0] w_cnt      [3];
    logic [EW-1:0] w_head     [3];
    logic          w_nonempty [3];
    logic          w_ovf_set  [3];

    logic          w_gnt_vld;
    logic [1:0]    w_gnt_idx;
    logic [EW-1:0] w_gnt_head;

    logic [1:0]    r_last_q, w_last_d;
    logic          r_rf_wr_en_q, w_rf_wr_en_d;
    logic [4:0]    r_rf_wr_addr_q, w_rf_wr_addr_d;
    logic [31:0]   r_rf_wr_data_q, w_rf_wr_data_d;
    logic [63:0]   r_instret_q, w_instret_d;
    logic          r_ovf_q, w_ovf_d;
    logic [1:0]    w_ret_cnt;

    assign w_src[0] = alu_wb_inf;
    assign w_src[1] = mem_wb_inf;
    assign w_src[2] = mul_wb_inf;

    // ------------------------------------------------------------------
    // Per-source FIFOs
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_src
        logic [PW-1:0] r_wr_ptr_q, w_wr_ptr_d;
        logic [PW-1:0] r_rd_ptr_q, w_rd_ptr_d;
        logic [CW-1:0] r_cnt_q, w_cnt_d;
        logic [EW-1:0] r_mem_q [FIFO_DEPTH];
        logic [EW-1:0] w_mem_d [FIFO_DEPTH];
        logic          w_push, w_pop, w_full, w_accept;

        always_comb begin
            w_push     = w_src[gi][38] & w_src[gi][37];
            w_pop      = w_gnt_vld & (w_gnt_idx == 2'(gi));
            w_full     = (r_cnt_q == c_cnt_full);
            // A same-cycle pop frees the head slot, so a push into a full
            // FIFO is still accepted; the write slot equals the head slot
            // and the head is read out by this same edge.
            w_accept   = w_push & (~w_full | w_pop);
            w_mem_d    = r_mem_q;
            w_wr_ptr_d = r_wr_ptr_q;
            w_rd_ptr_d = r_rd_ptr_q;
            w_cnt_d    = r_cnt_q;
            if (w_accept) begin
                w_mem_d[r_wr_ptr_q] = w_src[gi][36:0];
                w_wr_ptr_d          = r_wr_ptr_q + c_ptr_one;
            end
            if (w_pop) begin
                w_rd_ptr_d = r_rd_ptr_q + c_ptr_one;
            end
            case ({w_accept, w_pop})
                2'b10:   w_cnt_d = r_cnt_q + c_cnt_one;
                2'b01:   w_cnt_d = r_cnt_q - c_cnt_one;
                default: w_cnt_d = r_cnt_q;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_wr_ptr_q <= '0;
                r_rd_ptr_q <= '0;
                r_cnt_q    <= '0;
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    r_mem_q[i] <= '0;
                end
            end else begin
                r_wr_ptr_q <= w_wr_ptr_d;
                r_rd_ptr_q <= w_rd_ptr_d;
                r_cnt_q    <= w_cnt_d;
                r_mem_q    <= w_mem_d;
            end
        end

        assign w_cnt[gi]      = r_cnt_q;
        assign w_head[gi]     = r_mem_q[r_rd_ptr_q];
        assign w_nonempty[gi] = (r_cnt_q != '0);
        assign w_ovf_set[gi]  = w_push & w_full & ~w_pop;
    end

    // ------------------------------------------------------------------
    // Round-robin grant: search starts at the source after the last grant
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = 2'd0;
        case (r_last_q)
            2'd0: begin
                if      (w_nonempty[1]) begin w_gnt_vld = 1'b1; w_gnt_idx = 2'd1; end
                else if (w_nonempty[2]) begin w_gnt_vld = 1'b1; w_gnt_idx = 2'd2; end
                else if (w_nonempty[0]) begin w_gnt_vld = 1'b1; w_gnt_idx = 2'd0; end
            end
            2'd1: begin
                if      (w_nonempty[2]) begin w_gnt_vld = 1'b1; w_gnt_idx = 2'd2; end
                else if (w_nonempty[0]) begin w_gnt_vld = 1'b1; w_gnt_idx = 2'd0; end
                else if (w_nonempty[1]) begin w_gnt_vld = 1'b1; w_gnt_idx = 2'd1; end
            end
            default: begin
                if      (w_nonempty[0]) begin w_gnt_vld = 1'b1; w_gnt_idx = 2'd0; end
                else if (w_nonempty[1]) begin w_gnt_vld = 1'b1; w_gnt_idx = 2'd1; end
                else if (w_nonempty[2]) begin w_gnt_vld = 1'b1; w_gnt_idx = 2'd2; end
            end
        endcase
    end

    always_comb begin
        case (w_gnt_idx)
            2'd1:    w_gnt_head = w_head[1];
            2'd2:    w_gnt_head = w_head[2];
            default: w_gnt_head = w_head[0];
        endcase
    end

    // ------------------------------------------------------------------
    // Write port, grant pointer, retire counter, sticky overflow
    // ------------------------------------------------------------------
    always_comb begin
        w_last_d       = w_gnt_vld ? w_gnt_idx : r_last_q;
        w_rf_wr_en_d   = w_gnt_vld;
        // Address/data hold their last value when nothing is granted.
        w_rf_wr_addr_d = w_gnt_vld ? w_gnt_head[36:32] : r_rf_wr_addr_q;
        w_rf_wr_data_d = w_gnt_vld ? w_gnt_head[31:0]  : r_rf_wr_data_q;
        // Every valid instruction retires, including non-writing ones.
        w_ret_cnt      = {1'b0, w_src[0][38]} + {1'b0, w_src[1][38]} + {1'b0, w_src[2][38]};
        w_instret_d    = r_instret_q + {62'd0, w_ret_cnt};
        w_ovf_d        = r_ovf_q | w_ovf_set[0] | w_ovf_set[1] | w_ovf_set[2];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_q       <= 2'd2;
            r_rf_wr_en_q   <= 1'b0;
            r_rf_wr_addr_q <= '0;
            r_rf_wr_data_q <= '0;
            r_instret_q    <= '0;
            r_ovf_q        <= 1'b0;
        end else begin
            r_last_q       <= w_last_d;
            r_rf_wr_en_q   <= w_rf_wr_en_d;
            r_rf_wr_addr_q <= w_rf_wr_addr_d;
            r_rf_wr_data_q <= w_rf_wr_data_d;
            r_instret_q    <= w_instret_d;
            r_ovf_q        <= w_ovf_d;
        end
    end

    // Two entries of headroom: one result already in flight plus one more
    // issued before the registered stall reaches the producers.
    assign wb_stall     = (w_cnt[0] >= c_cnt_stall) |
                          (w_cnt[1] >= c_cnt_stall) |
                          (w_cnt[2] >= c_cnt_stall);
    assign rf_wr_en     = r_rf_wr_en_q;
    assign rf_wr_addr   = r_rf_wr_addr_q;
    assign rf_wr_data   = r_rf_wr_data_q;
    assign instret      = r_instret_q;
    assign overflow_err = r_ovf_q;

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback stage arbiter that sits directly downstream of the execution units (ALU, LSU, MUL/DIV). It absorbs their `exe_wb_inf_t` results into per-source FIFOs and issues at most one register-file write per cycle using round-robin priority. It raises a stall toward the core before any FIFO can overflow, and maintains the retired-instruction counter.

## Interface
- `FIFO_DEPTH`, default 4: entries per source FIFO. Power of two, ≥ 4.
- `clk` input 1: clock. All state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `alu_wb_inf` input `exe_wb_inf_t`: source 0 result (`instruction_valid`, `register_write`, `rd`, `exe_result`).
- `mem_wb_inf` input `exe_wb_inf_t`: source 1 result (LSU).
- `mul_wb_inf` input `exe_wb_inf_t`: source 2 result (MUL/DIV).
- `wb_stall` output 1: backpressure request to the core stall logic.
- `rf_wr_en` output 1: register-file write enable.
- `rf_wr_addr` output 5: register-file write address.
- `rf_wr_data` output 32: register-file write data.
- `instret` output 64: retired-instruction count.
- `overflow_err` output 1: sticky flag; a push arrived at a full FIFO.

## Operation
- **Push.** Source *i* pushes {`rd`, `exe_result`} into FIFO *i* when `instruction_valid & register_write`.
  - `rd == 0` is pushed like any other write; the rf_wr is issued, and the register file ignores x0.
- **Retire counting.** `instret += (number of sources with instruction_valid)` each cycle, 0..3. The count includes entries with `register_write = 0`. The counter is 64-bit unsigned and wraps from 2^64−1 to 0.
- **Arbitration.** Among non-empty FIFO heads, grant the first in order `(last+1)`, `(last+2)`, `(last+3)` mod 3, where `last` is the most recently granted source.
  - `last` updates only on a grant.
  - `last` resets to 2, so source 0 has priority first.
- **Pop.** On grant, the granted head is popped. At the next edge: `rf_wr_en=1`, `rf_wr_addr=head.rd`, `rf_wr_data=head.result`.
  - With no grant: `rf_wr_en=0`; addr/data hold their previous values.
- **Per-FIFO occupancy update.** `count' = count + push − pop`.
  - Push and pop in the same cycle on a full FIFO: push accepted, count stays `FIFO_DEPTH`.
  - Push on a full FIFO without a same-cycle pop: entry dropped, count unchanged, `overflow_err` set. `overflow_err` clears only on reset.
- **Stall.** `wb_stall` is combinational from registered counts: 1 when any `count ≥ FIFO_DEPTH−2`, else 0.
  - The margin of 2 covers the one-cycle registered latency of the producers plus the in-flight result.
- **Ordering.** Results within one source retire in FIFO order. No ordering is guaranteed across sources.
- **Flush.** No flush input. Results already delivered are architecturally committed and always drain.
- **Reset, async assert.**
  - All FIFO counts and pointers are cleared; contents are discarded.
  - `rf_wr_en=0`, `rf_wr_addr=0`, `rf_wr_data=0`, `instret=0`, `overflow_err=0`, `last=2`.
  - Consequently `wb_stall=0`.
  - Reset mid-drain discards pending entries with no write issued.
  - Deassertion is synchronised externally; the first push is accepted on the first rising edge after release.

## Timing
- Input valid in cycle t → captured at end of t → head visible in t+1 → arbitrated in t+1 → `rf_wr_en` high in cycle t+2. Minimum latency is 2 cycles.
- Throughput is one write per cycle. Three simultaneous pushes per cycle drain in 3 cycles.
- `wb_stall` rises in the cycle after the push that brings a count to `FIFO_DEPTH−2`. It falls in the cycle after the pop that lowers it below that level.
- `instret` updates at the end of the cycle in which `instruction_valid` is sampled, so it is visible 1 cycle later.

## Test plan
- **Reset defaults.** Assert `rst=0` mid-traffic with 3 entries pending → all outputs return to their reset values immediately. After release, no `rf_wr_en` occurs until a new push.
- **Single ALU result.** `rd=5`, result `0xDEADBEEF` in cycle 0 → `rf_wr_en=1`, addr 5, data `0xDEADBEEF` in cycle 2 only. `instret=1` visible from cycle 1.
- **Simultaneous writes from all sources.** ALU rd=1/0x11, LSU rd=2/0x22, MUL rd=3/0x33 in one cycle after reset → writes in cycles 2, 3, 4 in order rd 1, 2, 3. `instret` increments by 3.
- **Round-robin fairness.** ALU and LSU each push every cycle for 8 cycles with `FIFO_DEPTH=4` → grants alternate ALU, LSU, ALU, … . `wb_stall` asserts once a count reaches 2. No `overflow_err` while the producers honour the stall.
- **Overflow.** LSU pushes 6 consecutive cycles while ALU also pushes continuously and the stall is ignored → `overflow_err` goes to 1 and stays 1. Dropped entries never appear on rf_wr. Surviving entries retire in FIFO order.
- **Non-writing retire and wrap.** LSU store with `instruction_valid=1`, `register_write=0` → no push and no rf_wr, `instret` +1. Force `instret` to 2^64−2 (via backdoor) and then retire 3 instructions in one cycle → `instret=1`.
